// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode and handshake-state enums, plus the flag bundle
// that exists only when ALU_PIPE_FLAGS_EN is defined.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

`ifdef ALU_PIPE_FLAGS_EN
    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;
`endif

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational datapath of alu_pipe: one of eight operations on a_i/b_i.
// Condition flags are produced only when ALU_PIPE_FLAGS_EN is defined.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef ALU_PIPE_FLAGS_EN
    output flags_t           flags_o,
`endif
    output logic [WIDTH-1:0] result_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        result_o = '0;
        case (op_e'(op_i))
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_SHL:  result_o = a_i << shamt;
            OP_SHR:  result_o = a_i >> shamt;
            default: result_o = '0;
        endcase
    end

`ifdef ALU_PIPE_FLAGS_EN
    // One extra bit on each side captures the carry/borrow and the last bit shifted out.
    logic [WIDTH:0] sum_w, diff_w, shl_w, shr_w;
    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};
    assign shl_w  = {1'b0, a_i} << shamt;
    assign shr_w  = {a_i, 1'b0} >> shamt;

    always_comb begin
        flags_o   = '0;
        flags_o.z = (result_o == '0);
        case (op_e'(op_i))
            OP_ADD: begin
                flags_o.c = sum_w[WIDTH];
                flags_o.v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                flags_o.c = diff_w[WIDTH];
                flags_o.v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SHL:  flags_o.c = shl_w[WIDTH];
            OP_SHR:  flags_o.c = shr_w[0];
            default: flags_o.c = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Single-stage registered ALU with valid/ready handshakes and a chaining accumulator.
// Define ALU_PIPE_FLAGS_EN to add registered z/c/v flag outputs.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_PIPE_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
`endif
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, acc_q, a_eff, result_d;
    logic             accept;

    // A full stage can still accept when the consumer drains it on the same edge.
    assign in_ready = (state_q == ST_EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;
    assign a_eff    = use_acc ? acc_q : a;

`ifdef ALU_PIPE_FLAGS_EN
    flags_t flags_d, flags_q;
`endif

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op),
        .a_i      (a_eff),
        .b_i      (b),
`ifdef ALU_PIPE_FLAGS_EN
        .flags_o  (flags_d),
`endif
        .result_o (result_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            acc_q    <= ACC_RESET;
`ifdef ALU_PIPE_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q <= result_d;
`ifdef ALU_PIPE_FLAGS_EN
                flags_q  <= flags_d;
`endif
                if (acc_wr) acc_q <= result_d;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign result    = result_q;
    assign acc       = acc_q;
`ifdef ALU_PIPE_FLAGS_EN
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed plan steps, then random traffic
// compared against an arithmetic reference model of the handshake, ALU and accumulator.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, use_acc, acc_wr, out_valid, out_ready;
    logic [2:0] op;
    logic [7:0] a, b, result, acc;
`ifdef ALU_PIPE_FLAGS_EN
    logic       flag_z, flag_c, flag_v;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: is a result pending, its value/flags, and the accumulator.
    logic       m_valid;
    logic [7:0] m_res, m_acc;
    logic [2:0] m_flags;  // {v, c, z}

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .ACC_RESET(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .acc_wr    (acc_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ALU_PIPE_FLAGS_EN
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
`endif
        .result    (result),
        .acc       (acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {v, c, z, result[7:0]} computed with integer arithmetic.
    function automatic logic [10:0] ref_alu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int xi = x;
        int yi = y;
        int s  = yi % 8;
        int sx = (xi > 127) ? xi - 256 : xi;
        int sy = (yi > 127) ? yi - 256 : yi;
        int r  = 0;
        int c  = 0;
        int v  = 0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = 255 - xi;
            3'd4: begin
                r = (xi + yi) % 256;
                c = (xi + yi > 255) ? 1 : 0;
                v = (sx + sy > 127 || sx + sy < -128) ? 1 : 0;
            end
            3'd5: begin
                r = (xi - yi + 256) % 256;
                c = (xi < yi) ? 1 : 0;
                v = (sx - sy > 127 || sx - sy < -128) ? 1 : 0;
            end
            3'd6: begin
                r = (xi * (2 ** s)) % 256;
                c = (s == 0) ? 0 : ((xi * (2 ** s)) / 256) % 2;
            end
            default: begin
                r = xi / (2 ** s);
                c = (s == 0) ? 0 : (xi / (2 ** (s - 1))) % 2;
            end
        endcase
        return {v[0], c[0], (r == 0), r[7:0]};
    endfunction

    task automatic set_in(input logic iv, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic ua, input logic aw, input logic ordy);
        in_valid = iv; op = o; a = x; b = y; use_acc = ua; acc_wr = aw; out_ready = ordy;
    endtask

    // One clock: check in_ready, advance the model across the edge, then check outputs.
    task automatic cycle();
        logic       acc_ok, accept;
        logic [10:0] r;
        #1;
        acc_ok = !m_valid || out_ready;
        check("in_ready", in_ready, acc_ok);
        accept = in_valid && acc_ok;
        @(posedge clk);
        #1;
        if (accept) begin
            r       = ref_alu(op, use_acc ? m_acc : a, b);
            m_valid = 1'b1;
            m_res   = r[7:0];
            m_flags = r[10:8];
            if (acc_wr) m_acc = r[7:0];
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        check("out_valid", out_valid, m_valid);
        check("acc", acc, m_acc);
        if (m_valid) begin
            check("result", result, m_res);
`ifdef ALU_PIPE_FLAGS_EN
            check("flags", {flag_v, flag_c, flag_z}, m_flags);
`endif
        end
    endtask

    logic [2:0] b2b_ops [7];
    logic [7:0] b2b_exp [7];

    initial begin
        b2b_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        b2b_exp = '{8'h01, 8'hA7, 8'hA6, 8'h5A, 8'hA2, 8'h28, 8'h14};

        // Reset
        rst_n = 1'b0;
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b0; m_res = 8'h00; m_acc = 8'h00; m_flags = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_acc", acc, 8'h00);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Single ADD
        set_in(1'b1, 3'd4, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
        cycle();
        check("add_result", result, 8'h10);
`ifdef ALU_PIPE_FLAGS_EN
        check("add_flag_c", flag_c, 1'b1);
        check("add_flag_z", flag_z, 1'b0);
`endif

        // Back-to-back through the remaining operations
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, b2b_ops[i], 8'hA5, 8'h03, 1'b0, 1'b0, 1'b1);
            cycle();
            check("b2b_result", result, b2b_exp[i]);
        end

        // Backpressure: XOR accepted, then three stalled cycles with a pending request
        set_in(1'b1, 3'd2, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd4, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
            cycle();
            check("bp_held", result, 8'hF0);
            check("bp_in_ready", in_ready, 1'b0);
        end
        set_in(1'b1, 3'd4, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        cycle();
        check("bp_released", result, 8'h33);
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();

        // Accumulator chain
        set_in(1'b1, 3'd4, 8'h05, 8'h03, 1'b0, 1'b1, 1'b1);
        cycle();
        check("chain_r1", result, 8'h08);
        set_in(1'b1, 3'd4, 8'hEE, 8'h02, 1'b1, 1'b1, 1'b1);
        cycle();
        check("chain_r2", result, 8'h0A);
        check("chain_acc", acc, 8'h0A);

        // Async reset while FULL and stalled
        set_in(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        check("pre_rst_full", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_acc", acc, 8'h00);
        m_valid = 1'b0; m_acc = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's single-bit 2-bit-opcode logic unit: WIDTH-bit operands, 3-bit opcode, 8 operations.
- Single registered result stage with valid/ready handshakes on input and output.
- Internal accumulator lets results chain into the next operation.
- Sits between an operand source (sequencer/bench) and a result consumer; one operation per cycle at full throughput.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- ACC_RESET, 0, accumulator value after reset (WIDTH bits)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept the request this cycle
- op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 ADD, 5 SUB(a-b), 6 SHL(a by b[log2 WIDTH-1:0]), 7 SHR logical
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- use_acc  input  1  1: operand A is replaced by the accumulator
- acc_wr  input  1  1: result is also written into the accumulator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (async assert, sync release): out_valid=0, result=0, acc=ACC_RESET, state=EMPTY.
- Two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, result held stable.
- in_ready = (state==EMPTY) | out_ready. Combinational from out_ready only; no path from in_valid.
- Accept = in_valid & in_ready.
  - On accept, the result is computed from inputs sampled that cycle and registered.
  - out_valid=1 the next cycle; latency is 1 cycle.
- Transitions:
  - EMPTY, accept -> FULL.
  - FULL, out_ready & accept -> FULL, new result (back-to-back, 1 op/cycle).
  - FULL, out_ready & !accept -> EMPTY.
  - FULL, !out_ready -> FULL; result and acc unchanged; in_ready=0.
- Operand A effective = use_acc ? acc : a.
  - The accumulator value used is the one registered before this accept, so a chained op sees the previous acc_wr result.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shift amount is b[$clog2(WIDTH)-1:0]; vacated bits are filled with 0.
  - NOT ignores b.
- Accumulator is updated on the same edge that result is registered, only if accept & acc_wr.
- in_valid while in_ready=0: no state change; the requester must hold its inputs.
- out_ready while EMPTY is ignored.
- Reset mid-operation: any held result is discarded, out_valid drops immediately (async), acc returns to ACC_RESET.

Optional Feature:
- Macro ALU_PIPE_FLAGS_EN.
- Defined: adds outputs flag_z (1), flag_c (1), flag_v (1), registered alongside result and held with it.
  - z: result==0.
  - c: carry-out for ADD; borrow (a<b unsigned) for SUB; last bit shifted out for SHL/SHR; 0 for logic ops.
  - v: signed overflow for ADD/SUB; 0 otherwise.
  - Reset value 0.
- Undefined: flag ports and logic are absent.

Decomposition:
- Package alu_pipe_pkg holds:
  - op enum (OP_AND..OP_SHR, 3 bits)
  - state enum (ST_EMPTY, ST_FULL)
  - flag struct when flags are enabled
- One combinational sub-module, alu_pipe_core:
  - inputs: op, a_eff, b
  - outputs: next result (and flags)
  - alu_pipe keeps all registers, the handshake and the accumulator.

Test Plan:
- Reset, WIDTH=8: hold rst_n=0 -> out_valid=0, result=0, acc=0; release, in_ready=1.
- Single op, out_ready=1: op=ADD, a=8'hF0, b=8'h20 -> next cycle out_valid=1, result=8'h10; with flags, flag_c=1, flag_z=0.
- Back-to-back, out_ready=1: AND/OR/XOR/NOT/SUB/SHL/SHR on a=8'hA5, b=8'h03 over 7 cycles.
  - results 01, A7, A6, 5A, A2, 28, 14 on consecutive cycles; in_ready stays 1.
- Backpressure:
  - Issue XOR a=8'hFF, b=8'h0F, then hold out_ready=0 for 3 cycles while in_valid=1.
  - Required: result=8'hF0 held, in_ready=0, second op not accepted until out_ready=1.
- Accumulator chain: ADD a=5, b=3, acc_wr=1; then ADD use_acc=1, b=2, acc_wr=1 -> results 8, 10; acc=10.
- Async reset mid-operation: assert rst_n while FULL with out_ready=0 -> out_valid=0 before the next clock edge, acc=ACC_RESET.
